// File: rtl/tlc_pkg.sv
// ============================================================================
// tlc_pkg : shared lamp encodings, monitor states and fault codes
// Revision 1.0
// ============================================================================
`default_nettype none

package tlc_pkg;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  typedef enum logic [1:0] {
    MON_NORMAL  = 2'd0,
    MON_FLASH   = 2'd1,
    MON_RECOVER = 2'd2
  } mon_state_t;

  localparam logic [2:0] FC_NONE    = 3'd0;
  localparam logic [2:0] FC_INVALID = 3'd1;
  localparam logic [2:0] FC_S_CONF  = 3'd2;
  localparam logic [2:0] FC_MT_CONF = 3'd3;
  localparam logic [2:0] FC_WDOG    = 3'd4;

  typedef struct packed {
    logic [2:0] m1;
    logic [2:0] m2;
    logic [2:0] mt;
    logic [2:0] s;
  } lamps_t;

  localparam lamps_t LAMPS_ALL_RED = {LAMP_RED, LAMP_RED, LAMP_RED, LAMP_RED};

  function automatic logic lamp_onehot(input logic [2:0] l);
    return (l == LAMP_RED) || (l == LAMP_YEL) || (l == LAMP_GRN);
  endfunction

  function automatic logic lamp_green(input logic [2:0] l);
    return (l == LAMP_GRN);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tlc_flasher.sv
// ============================================================================
// tlc_flasher : half-period counter with phase toggle for the fault flash
// Revision 1.0
// ============================================================================
`default_nettype none

module tlc_flasher #(
  parameter int FLASH_HALF = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic phase
);

  localparam int CW = (FLASH_HALF < 1) ? 1 : $clog2(FLASH_HALF + 1);
  localparam logic [CW-1:0] c_cnt_last = CW'(FLASH_HALF - 1);

  logic [CW-1:0] r_cnt;
  logic          r_phase;

  // restart parks the flasher so the first flash half is always lamps-on
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_phase <= 1'b1;
    end else if (restart) begin
      r_cnt   <= '0;
      r_phase <= 1'b1;
    end else if (r_cnt == c_cnt_last) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + CW'(1);
    end
  end

  assign phase = r_phase;

endmodule

`default_nettype wire

// File: rtl/tlc_conflict_monitor.sv
// ============================================================================
// tlc_conflict_monitor : registers controller lamp buses, detects illegal or
// conflicting aspects and a stalled controller, and forces flashing red.
// Revision 1.0
// ============================================================================
`default_nettype none

module tlc_conflict_monitor
  import tlc_pkg::*;
#(
  parameter int DEBOUNCE    = 2,
  parameter int WDOG        = 64,
  parameter int FLASH_HALF  = 4,
  parameter int RECOVER_CYC = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light_M1,
  input  logic [2:0] light_M2,
  input  logic [2:0] light_MT,
  input  logic [2:0] light_S,
  input  logic       clr,
  output logic [2:0] drv_M1,
  output logic [2:0] drv_M2,
  output logic [2:0] drv_MT,
  output logic [2:0] drv_S,
  output logic       fault,
  output logic [2:0] fault_code
);

  localparam int VW = $clog2(DEBOUNCE + 1);
  localparam int WW = $clog2(WDOG + 1);
  localparam int RW = $clog2(RECOVER_CYC + 1);

  localparam logic [VW-1:0] c_viol_last = VW'(DEBOUNCE - 1);
  localparam logic [VW-1:0] c_viol_max  = VW'(DEBOUNCE);
  localparam logic [WW-1:0] c_wd_last   = WW'(WDOG - 1);
  localparam logic [WW-1:0] c_wd_max    = WW'(WDOG);
  localparam logic [RW-1:0] c_rec_last  = RW'(RECOVER_CYC - 1);

  lamps_t        w_in;
  lamps_t        r_in_q;
  lamps_t        r_prev_q;
  lamps_t        r_drv;
  lamps_t        w_drv_nxt;
  mon_state_t    r_state;
  mon_state_t    w_state_nxt;
  logic [VW-1:0] r_viol_cnt;
  logic [VW-1:0] w_viol_nxt;
  logic [WW-1:0] r_wd_cnt;
  logic [WW-1:0] w_wd_nxt;
  logic [RW-1:0] r_rec_cnt;
  logic [RW-1:0] w_rec_nxt;
  logic [2:0]    r_code;
  logic [2:0]    w_code_nxt;

  logic          w_bad_enc;
  logic          w_s_conf;
  logic          w_mt_conf;
  logic          w_viol;
  logic [2:0]    w_cause;
  logic          w_in_chg;
  logic          w_trip_viol;
  logic          w_trip_wd;
  logic          w_restart;
  logic          w_phase;
  logic [2:0]    w_flash_lamp;

  assign w_in = {light_M1, light_M2, light_MT, light_S};

  // Violation decode works on the registered sample only
  assign w_bad_enc = !lamp_onehot(r_in_q.m1) || !lamp_onehot(r_in_q.m2) ||
                     !lamp_onehot(r_in_q.mt) || !lamp_onehot(r_in_q.s);
  assign w_s_conf  = lamp_green(r_in_q.s) &&
                     (lamp_green(r_in_q.m1) || lamp_green(r_in_q.m2) ||
                      lamp_green(r_in_q.mt));
  assign w_mt_conf = lamp_green(r_in_q.mt) && lamp_green(r_in_q.m2);
  assign w_viol    = w_bad_enc || w_s_conf || w_mt_conf;

  always_comb begin
    w_cause = FC_NONE;
    if (w_bad_enc)      w_cause = FC_INVALID;
    else if (w_s_conf)  w_cause = FC_S_CONF;
    else if (w_mt_conf) w_cause = FC_MT_CONF;
  end

  assign w_in_chg    = (r_in_q != r_prev_q);
  assign w_trip_viol = w_viol && (r_viol_cnt == c_viol_last);
  assign w_trip_wd   = !w_in_chg && (r_wd_cnt == c_wd_last);

  assign w_restart = (r_state != MON_FLASH) || clr;

  tlc_flasher #(
    .FLASH_HALF (FLASH_HALF)
  ) u_flasher (
    .clk     (clk),
    .rst     (rst),
    .restart (w_restart),
    .phase   (w_phase)
  );

  assign w_flash_lamp = w_phase ? LAMP_RED : LAMP_OFF;

  always_comb begin
    w_state_nxt = r_state;
    w_drv_nxt   = r_drv;
    w_code_nxt  = r_code;
    w_rec_nxt   = '0;

    if (!w_viol)                      w_viol_nxt = '0;
    else if (r_viol_cnt == c_viol_max) w_viol_nxt = r_viol_cnt;
    else                              w_viol_nxt = r_viol_cnt + VW'(1);

    if ((r_state != MON_NORMAL) || w_in_chg) w_wd_nxt = '0;
    else if (r_wd_cnt == c_wd_max)            w_wd_nxt = r_wd_cnt;
    else                                      w_wd_nxt = r_wd_cnt + WW'(1);

    case (r_state)
      MON_NORMAL: begin
        w_drv_nxt = r_in_q;
        if (w_trip_viol) begin
          w_state_nxt = MON_FLASH;
          w_code_nxt  = w_cause;
          w_drv_nxt   = LAMPS_ALL_RED;
        end else if (w_trip_wd) begin
          w_state_nxt = MON_FLASH;
          w_code_nxt  = FC_WDOG;
          w_drv_nxt   = LAMPS_ALL_RED;
        end
      end
      MON_FLASH: begin
        w_drv_nxt = LAMPS_ALL_RED;
        if (clr) begin
          w_state_nxt = MON_RECOVER;
        end
      end
      MON_RECOVER: begin
        w_drv_nxt = LAMPS_ALL_RED;
        // a fresh conflict during recovery re-trips without debounce
        if (w_viol) begin
          w_state_nxt = MON_FLASH;
          w_code_nxt  = w_cause;
        end else if (r_rec_cnt == c_rec_last) begin
          w_state_nxt = MON_NORMAL;
          w_code_nxt  = FC_NONE;
          w_drv_nxt   = r_in_q;
          w_viol_nxt  = '0;
          w_wd_nxt    = '0;
        end else begin
          w_rec_nxt = r_rec_cnt + RW'(1);
        end
      end
      default: begin
        w_state_nxt = MON_NORMAL;
        w_drv_nxt   = LAMPS_ALL_RED;
        w_code_nxt  = FC_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= MON_NORMAL;
      r_in_q     <= LAMPS_ALL_RED;
      r_prev_q   <= LAMPS_ALL_RED;
      r_drv      <= LAMPS_ALL_RED;
      r_viol_cnt <= '0;
      r_wd_cnt   <= '0;
      r_rec_cnt  <= '0;
      r_code     <= FC_NONE;
    end else begin
      r_state    <= w_state_nxt;
      r_in_q     <= w_in;
      r_prev_q   <= r_in_q;
      r_drv      <= w_drv_nxt;
      r_viol_cnt <= w_viol_nxt;
      r_wd_cnt   <= w_wd_nxt;
      r_rec_cnt  <= w_rec_nxt;
      r_code     <= w_code_nxt;
    end
  end

  // Flash aspect comes straight from the flasher phase register
  assign drv_M1     = (r_state == MON_FLASH) ? w_flash_lamp : r_drv.m1;
  assign drv_M2     = (r_state == MON_FLASH) ? w_flash_lamp : r_drv.m2;
  assign drv_MT     = (r_state == MON_FLASH) ? w_flash_lamp : r_drv.mt;
  assign drv_S      = (r_state == MON_FLASH) ? w_flash_lamp : r_drv.s;
  assign fault      = (r_state != MON_NORMAL);
  assign fault_code = r_code;

endmodule

`default_nettype wire

// File: tb/tb_tlc_conflict_monitor.sv
// ============================================================================
// tb_tlc_conflict_monitor : directed self-checking bench for the monitor
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_tlc_conflict_monitor;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  localparam logic [11:0] ALLR = {R, R, R, R};
  localparam logic [11:0] ALLO = 12'h000;
  localparam logic [11:0] S1   = {G, G, R, R};
  localparam logic [11:0] S2   = {G, Y, R, R};
  localparam logic [11:0] S3   = {G, R, G, R};
  localparam logic [11:0] S4   = {Y, R, Y, R};
  localparam logic [11:0] S5   = {R, R, R, G};
  localparam logic [11:0] S6   = {R, R, R, Y};
  localparam logic [11:0] SCON = {G, R, R, G};
  localparam logic [11:0] MCON = {R, G, G, R};
  localparam logic [11:0] GLT  = {G, 3'b011, R, R};

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic [2:0] light_M1, light_M2, light_MT, light_S;
  logic [2:0] drv_M1, drv_M2, drv_MT, drv_S;
  logic       fault;
  logic [2:0] fault_code;
  logic [11:0] w_drv;

  int n_checks = 0;
  int n_pass   = 0;

  assign w_drv = {drv_M1, drv_M2, drv_MT, drv_S};

  tlc_conflict_monitor #(
    .DEBOUNCE    (2),
    .WDOG        (64),
    .FLASH_HALF  (4),
    .RECOVER_CYC (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .light_M1   (light_M1),
    .light_M2   (light_M2),
    .light_MT   (light_MT),
    .light_S    (light_S),
    .clr        (clr),
    .drv_M1     (drv_M1),
    .drv_M2     (drv_M2),
    .drv_MT     (drv_MT),
    .drv_S      (drv_S),
    .fault      (fault),
    .fault_code (fault_code)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lights(input logic [11:0] v);
    {light_M1, light_M2, light_MT, light_S} = v;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clr = 1'b0;
    set_lights(ALLR);
    repeat (3) tick();
    n_checks++;
    if (w_drv !== ALLR) $display("FAIL reset_drv: got %h expected %h", w_drv, ALLR);
    else n_pass++;
    n_checks++;
    if (fault !== 1'b0) $display("FAIL reset_fault: got %b expected 0", fault);
    else n_pass++;
    n_checks++;
    if (fault_code !== 3'd0) $display("FAIL reset_code: got %0d expected 0", fault_code);
    else n_pass++;
    rst = 1'b0;
    tick();
    tick();
    n_checks++;
    if (w_drv !== ALLR) $display("FAIL post_reset_drv: got %h expected %h", w_drv, ALLR);
    else n_pass++;
  endtask

  task automatic test_passthrough();
    logic [11:0] pats [6];
    logic [11:0] prev;
    pats = '{S1, S2, S3, S4, S5, S6};
    prev = ALLR;
    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < 6; p++) begin
        for (int h = 0; h < 3; h++) begin
          set_lights(pats[p]);
          tick();
          n_checks++;
          if (w_drv !== prev)
            $display("FAIL passthru r%0d p%0d h%0d: got %h expected %h", r, p, h, w_drv, prev);
          else n_pass++;
          prev = pats[p];
        end
      end
    end
    n_checks++;
    if (fault !== 1'b0) $display("FAIL passthru_fault: got %b expected 0", fault);
    else n_pass++;
  endtask

  task automatic test_s_conflict();
    set_lights(SCON);
    tick();
    tick();
    n_checks++;
    if (w_drv !== SCON) $display("FAIL sconf_leak: got %h expected %h", w_drv, SCON);
    else n_pass++;
    n_checks++;
    if (fault !== 1'b0) $display("FAIL sconf_early_fault: got %b expected 0", fault);
    else n_pass++;
    tick();
    n_checks++;
    if (fault !== 1'b1 || fault_code !== 3'd2)
      $display("FAIL sconf_trip: fault=%b code=%0d expected 1/2", fault, fault_code);
    else n_pass++;
    n_checks++;
    if (w_drv !== ALLR) $display("FAIL sconf_flash0: got %h expected %h", w_drv, ALLR);
    else n_pass++;
    for (int k = 1; k < 4; k++) begin
      tick();
      n_checks++;
      if (w_drv !== ALLR) $display("FAIL sconf_flash_on%0d: got %h expected %h", k, w_drv, ALLR);
      else n_pass++;
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if (w_drv !== ALLO) $display("FAIL sconf_flash_off%0d: got %h expected %h", k, w_drv, ALLO);
      else n_pass++;
    end
    tick();
    n_checks++;
    if (w_drv !== ALLR) $display("FAIL sconf_flash_rewrap: got %h expected %h", w_drv, ALLR);
    else n_pass++;
    // operator clear with a legal, distinguishable pattern
    set_lights(S1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_checks++;
    if (w_drv !== ALLR || fault !== 1'b1)
      $display("FAIL sconf_recover_start: drv=%h fault=%b expected %h/1", w_drv, fault, ALLR);
    else n_pass++;
    for (int k = 1; k < 8; k++) begin
      tick();
      n_checks++;
      if (w_drv !== ALLR || fault !== 1'b1)
        $display("FAIL sconf_recover%0d: drv=%h fault=%b expected %h/1", k, w_drv, fault, ALLR);
      else n_pass++;
    end
    tick();
    n_checks++;
    if (w_drv !== S1 || fault !== 1'b0 || fault_code !== 3'd0)
      $display("FAIL sconf_normal: drv=%h fault=%b code=%0d expected %h/0/0", w_drv, fault, fault_code, S1);
    else n_pass++;
  endtask

  task automatic test_glitch();
    set_lights(GLT);
    tick();
    set_lights(S1);
    tick();
    n_checks++;
    if (w_drv !== GLT || fault !== 1'b0)
      $display("FAIL glitch_show: drv=%h fault=%b expected %h/0", w_drv, fault, GLT);
    else n_pass++;
    tick();
    n_checks++;
    if (w_drv !== S1 || fault !== 1'b0)
      $display("FAIL glitch_after: drv=%h fault=%b expected %h/0", w_drv, fault, S1);
    else n_pass++;
    // alternating single glitches must not accumulate
    set_lights(GLT); tick();
    set_lights(S1);  tick();
    set_lights(GLT); tick();
    set_lights(S1);  tick();
    tick();
    n_checks++;
    if (fault !== 1'b0) $display("FAIL glitch_alternate: fault=%b expected 0", fault);
    else n_pass++;
    set_lights(GLT);
    tick();
    tick();
    set_lights(S1);
    tick();
    n_checks++;
    if (fault !== 1'b1 || fault_code !== 3'd1)
      $display("FAIL glitch_held: fault=%b code=%0d expected 1/1", fault, fault_code);
    else n_pass++;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (7) tick();
    tick();
    n_checks++;
    if (fault !== 1'b0 || fault_code !== 3'd0 || w_drv !== S1)
      $display("FAIL glitch_clear: fault=%b code=%0d drv=%h expected 0/0/%h", fault, fault_code, w_drv, S1);
    else n_pass++;
  endtask

  task automatic test_watchdog();
    logic found;
    set_lights(S2);
    tick();
    set_lights(S1);
    repeat (60) tick();
    n_checks++;
    if (fault !== 1'b0) $display("FAIL wdog_early: fault=%b expected 0", fault);
    else n_pass++;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (fault === 1'b1) found = 1'b1;
    end
    n_checks++;
    if (found !== 1'b1) $display("FAIL wdog_timeout: trip seen=%b expected 1", found);
    else n_pass++;
    n_checks++;
    if (fault_code !== 3'd4) $display("FAIL wdog_code: got %0d expected 4", fault_code);
    else n_pass++;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_checks++;
    if (w_drv !== ALLR || fault !== 1'b1)
      $display("FAIL wdog_recover0: drv=%h fault=%b expected %h/1", w_drv, fault, ALLR);
    else n_pass++;
    for (int k = 1; k < 8; k++) begin
      tick();
      n_checks++;
      if (w_drv !== ALLR) $display("FAIL wdog_recover%0d: got %h expected %h", k, w_drv, ALLR);
      else n_pass++;
    end
    tick();
    n_checks++;
    if (fault !== 1'b0 || fault_code !== 3'd0 || w_drv !== S1)
      $display("FAIL wdog_normal: fault=%b code=%0d drv=%h expected 0/0/%h", fault, fault_code, w_drv, S1);
    else n_pass++;
  endtask

  task automatic test_recover_conflict();
    set_lights(SCON);
    repeat (3) tick();
    n_checks++;
    if (fault_code !== 3'd2) $display("FAIL rconf_setup: code=%0d expected 2", fault_code);
    else n_pass++;
    set_lights(S1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    tick();
    set_lights(MCON);
    tick();
    n_checks++;
    if (fault !== 1'b1 || fault_code !== 3'd2 || w_drv !== ALLR)
      $display("FAIL rconf_pre: fault=%b code=%0d drv=%h expected 1/2/%h", fault, fault_code, w_drv, ALLR);
    else n_pass++;
    tick();
    n_checks++;
    if (fault !== 1'b1 || fault_code !== 3'd3)
      $display("FAIL rconf_trip: fault=%b code=%0d expected 1/3", fault, fault_code);
    else n_pass++;
    repeat (4) tick();
    n_checks++;
    if (w_drv !== ALLO) $display("FAIL rconf_flashing: got %h expected %h", w_drv, ALLO);
    else n_pass++;
    set_lights(S1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (7) tick();
    tick();
    n_checks++;
    if (fault !== 1'b0 || fault_code !== 3'd0 || w_drv !== S1)
      $display("FAIL rconf_normal: fault=%b code=%0d drv=%h expected 0/0/%h", fault, fault_code, w_drv, S1);
    else n_pass++;
  endtask

  task automatic test_clr_in_normal();
    set_lights(S2);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_checks++;
    if (fault !== 1'b0 || fault_code !== 3'd0 || w_drv !== S1)
      $display("FAIL clr_normal0: fault=%b code=%0d drv=%h expected 0/0/%h", fault, fault_code, w_drv, S1);
    else n_pass++;
    tick();
    n_checks++;
    if (fault !== 1'b0 || w_drv !== S2)
      $display("FAIL clr_normal1: fault=%b drv=%h expected 0/%h", fault, w_drv, S2);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    set_lights(SCON);
    repeat (3) tick();
    repeat (4) tick();
    n_checks++;
    if (w_drv !== ALLO || fault !== 1'b1)
      $display("FAIL areset_setup: drv=%h fault=%b expected %h/1", w_drv, fault, ALLO);
    else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (w_drv !== ALLR || fault !== 1'b0 || fault_code !== 3'd0)
      $display("FAIL areset_immediate: drv=%h fault=%b code=%0d expected %h/0/0", w_drv, fault, fault_code, ALLR);
    else n_pass++;
    set_lights(S3);
    tick();
    rst = 1'b0;
    tick();
    tick();
    n_checks++;
    if (w_drv !== S3 || fault !== 1'b0)
      $display("FAIL areset_resume: drv=%h fault=%b expected %h/0", w_drv, fault, S3);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_s_conflict();
    test_glitch();
    test_watchdog();
    test_recover_conflict();
    test_clr_in_normal();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tlc_conflict_monitor.md
# tlc_conflict_monitor

Safety stage directly downstream of the traffic light controller. It registers the four 3-bit lamp buses (M1, M2, MT, S) and checks every sample for illegal encodings, conflicting greens and a stalled controller. Clean samples pass through to the lamp drivers. On a persistent violation it latches a fault code and overrides all lamps with flashing red until an operator clear and a solid-red recovery interval complete.

## Interface
Parameters:
- DEBOUNCE, 2: consecutive violating samples required to trip (≥1).
- WDOG, 64: NORMAL-state cycles with unchanged inputs before a watchdog trip.
- FLASH_HALF, 4: cycles per flash half-period.
- RECOVER_CYC, 8: solid-red cycles after a clear before returning to NORMAL.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- light_M1, light_M2, light_MT, light_S  in  3 each  controller lamp buses, one-hot: 100 red, 010 yellow, 001 green.
- clr  in  1  single-cycle fault clear request.
- drv_M1, drv_M2, drv_MT, drv_S  out  3 each  lamp driver outputs, same encoding.
- fault  out  1  high in FLASH and RECOVER.
- fault_code  out  3  latched cause: 0 none, 1 invalid encoding, 2 S conflict, 3 MT/M2 conflict, 4 watchdog.

## Operation
- Input stage: all four buses are registered into in_q every cycle. All checks use in_q only.
- Violation classes, evaluated in this priority order:
  - Code 1: any in_q bus not one-hot (000, 011, 111, …).
  - Code 2: S green while any of M1, M2 or MT is green.
  - Code 3: MT green while M2 is green.
  - Code 4: watchdog. Only in NORMAL: wd_cnt reaches WDOG.
- M1+M2 green, M1+MT green and any yellow combination are legal.
- Transitions without yellow (e.g. S 001→100) are legal.
- viol_cnt: increments on each cycle with a code 1–3 violation. It resets to 0 on any clean cycle.
- Trip: the trip fires when a code 1–3 violation is present and viol_cnt == DEBOUNCE-1, or when wd_cnt == WDOG-1 and in_q is unchanged.
- wd_cnt: clears when in_q differs from its previous value. It is held at 0 outside NORMAL.
- States:
  - NORMAL: drv <= in_q. Trip → FLASH, fault_code <= cause (highest priority cause present).
  - FLASH: all four drv <= phase ? 100 : 000. phase = 1 and flash_cnt = 0 on entry. flash_cnt counts 0..FLASH_HALF-1, and phase toggles at wrap. clr → RECOVER.
  - RECOVER: all drv <= 100 solid, rec_cnt counts 0..RECOVER_CYC-1. A code 1–3 violation on any cycle → FLASH with the new code, with no debounce. Otherwise, at wrap → NORMAL with fault_code <= 0 and viol_cnt, wd_cnt cleared.
- clr is ignored in NORMAL and RECOVER.
- In FLASH, clr has priority over the flash counter update.
- All counters are sized $clog2(max+1) and never wrap beyond their limits.

## Timing
- Reset values:
  - in_q = 100 on all four buses.
  - drv_* = 100.
  - fault = 0, fault_code = 0.
  - State NORMAL, all counters 0, phase 1.
- Pass-through latency is 2 cycles: a bus changes at edge N, appears in in_q at N+1 and on drv at N+2.
- drv, fault and fault_code update on the same edge as the state transition.
- A violation on the inputs at edge N puts FLASH on drv at edge N+1+DEBOUNCE.
  - With DEBOUNCE=1, a conflicting pattern never reaches drv.
  - With DEBOUNCE=k, it reaches drv for k-1 cycles.
- After clr is sampled at edge C: RECOVER starts at C. NORMAL starts at C+RECOVER_CYC with drv = in_q.
- Asserting rst mid-FLASH or mid-RECOVER returns all outputs to reset values immediately, i.e. asynchronously.

## Structure
- The shared package tlc_pkg holds:
  - Lamp encodings LAMP_RED=3'b100, LAMP_YEL=3'b010, LAMP_GRN=3'b001, LAMP_OFF=3'b000.
  - Monitor state enum {MON_NORMAL, MON_FLASH, MON_RECOVER}.
  - Fault code constants FC_NONE..FC_WDOG.
- Sub-module tlc_flasher is natural. It is the FLASH_HALF counter plus phase toggle, with inputs clk, rst and restart, and output phase.
- Violation decode is combinational inside tlc_conflict_monitor.

## Test plan
- Controller pattern sequence s1..s6, repeated twice (M1/M2 001→010→100 and so on, S 001→100) → drv equals the inputs delayed 2 cycles, fault stays 0.
- S=001 and M1=001 held, DEBOUNCE=2 → NORMAL drv shows the conflict for 1 cycle. FLASH starts at N+3 with fault=1 and fault_code=2. drv follows 100×4 cycles, 000×4 cycles, repeating.
- One-cycle glitch M2=011, DEBOUNCE=2 → no trip, viol_cnt returns to 0, drv shows 011 once. Glitch held for 2 cycles → fault_code=1.
- Inputs frozen at the s1 pattern for 64 cycles → watchdog trip with fault_code=4. clr then gives 8 cycles of solid 100, then NORMAL with fault_code=0.
- In RECOVER, apply MT=001 and M2=001 → immediate FLASH with fault_code=3. clr pulsed during NORMAL → no effect.
- rst asserted mid-FLASH between clock edges → drv=100, fault=0 and fault_code=0 immediately. Operation resumes in NORMAL after rst deasserts.
